// File: rtl/fpu_add_post.sv
// FPU adder back end: effective add/subtract of aligned mantissas, normalization,
// round-to-nearest-even and IEEE-754 single-precision packing.
// Three register stages (sum, normalized, packed) with a single global enable.
// A stalled output freezes the whole pipeline.
module fpu_add_post #(
    parameter int unsigned LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_s_a,
    input  logic        in_s_b,
    input  logic        in_c,
    input  logic        in_eq,
    input  logic [7:0]  in_exp,
    input  logic [27:0] in_ma,
    input  logic [27:0] in_mb,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_overflow,
    output logic        out_inexact
);

    // The pipeline depth is structural; a different LAT cannot be honoured.
    if (LAT != 3) begin : g_lat_check
        $error("fpu_add_post supports LAT = 3 only");
    end

    logic en;

    // stage 1: sum
    logic               s1_valid_q;
    logic               s1_sign_q,  s1_sign_d;
    logic [27:0]        s1_sum_q,   s1_sum_d;
    logic signed [9:0]  s1_exp_q,   s1_exp_d;

    // stage 2: normalized mantissa (bit 26 = hidden, 2:0 = G/R/S)
    logic               s2_valid_q;
    logic               s2_sign_q;
    logic               s2_zero_q,  s2_zero_d;
    logic [26:0]        s2_man_q,   s2_man_d;
    logic signed [9:0]  s2_exp_q,   s2_exp_d;

    // stage 3: packed result
    logic               out_valid_q;
    logic [31:0]        out_result_q, out_result_d;
    logic               out_overflow_q, out_overflow_d;
    logic               out_inexact_q,  out_inexact_d;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    // Stage 1 combinational: effective operation, sign selection.
    always_comb begin
        logic sub;
        sub       = in_s_a ^ in_s_b;
        s1_sum_d  = sub ? (in_ma - in_mb) : (in_ma + in_mb);
        s1_sign_d = (sub && in_eq) ? 1'b0 : (in_c ? in_s_a : in_s_b);
        s1_exp_d  = $signed({2'b00, in_exp});
    end

    // Stage 2 combinational: normalize; left shift is capped so the exponent
    // never drops below 1, leaving a subnormal with exponent field 0.
    always_comb begin
        logic [4:0]        lz;
        logic [4:0]        sh;
        logic signed [9:0] lim;
        logic [26:0]       shifted;
        s2_man_d  = '0;
        s2_exp_d  = s1_exp_q;
        s2_zero_d = 1'b0;
        lz        = 5'd27;
        sh        = 5'd0;
        lim       = s1_exp_q - 10'sd1;
        shifted   = '0;
        for (int i = 0; i <= 26; i++) begin
            if (s1_sum_q[i]) begin
                lz = 5'(26 - i);
            end
        end
        if (s1_sum_q[27]) begin
            s2_man_d = {s1_sum_q[27:2], s1_sum_q[1] | s1_sum_q[0]};
            s2_exp_d = s1_exp_q + 10'sd1;
        end else if (s1_sum_q == 28'd0) begin
            s2_zero_d = 1'b1;
            s2_exp_d  = 10'sd0;
        end else begin
            if (lim <= 10'sd0) begin
                sh = 5'd0;
            end else if ($signed({5'b00000, lz}) < lim) begin
                sh = lz;
            end else begin
                sh = lim[4:0];
            end
            shifted  = s1_sum_q[26:0] << sh;
            s2_man_d = shifted;
            s2_exp_d = shifted[26] ? (s1_exp_q - $signed({5'b00000, sh})) : 10'sd0;
        end
    end

    // Stage 3 combinational: RNE rounding, overflow detection and packing.
    always_comb begin
        logic              g, r, st, lsb, round_up;
        logic [24:0]       rnd;
        logic [22:0]       frac;
        logic signed [9:0] exp_r;
        g        = s2_man_q[2];
        r        = s2_man_q[1];
        st       = s2_man_q[0];
        lsb      = s2_man_q[3];
        round_up = g & (r | st | lsb);
        rnd      = {1'b0, s2_man_q[26:3]} + {24'd0, round_up};
        if (rnd[24]) begin
            frac  = rnd[23:1];
            exp_r = s2_exp_q + 10'sd1;
        end else begin
            frac  = rnd[22:0];
            exp_r = ((s2_exp_q == 10'sd0) && rnd[23]) ? 10'sd1 : s2_exp_q;
        end
        out_result_d   = {s2_sign_q, exp_r[7:0], frac};
        out_overflow_d = 1'b0;
        out_inexact_d  = g | r | st;
        if (s2_zero_q) begin
            out_result_d  = {s2_sign_q, 31'h0};
            out_inexact_d = 1'b0;
        end else if (exp_r >= 10'sd255) begin
            out_result_d   = {s2_sign_q, 8'hFF, 23'h0};
            out_overflow_d = 1'b1;
        end
    end

    // Pipeline registers: all stages advance together when en is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q     <= 1'b0;
            s1_sign_q      <= 1'b0;
            s1_sum_q       <= '0;
            s1_exp_q       <= '0;
            s2_valid_q     <= 1'b0;
            s2_sign_q      <= 1'b0;
            s2_zero_q      <= 1'b0;
            s2_man_q       <= '0;
            s2_exp_q       <= '0;
            out_valid_q    <= 1'b0;
            out_result_q   <= '0;
            out_overflow_q <= 1'b0;
            out_inexact_q  <= 1'b0;
        end else if (en) begin
            s1_valid_q  <= in_valid;
            s1_sign_q   <= s1_sign_d;
            s1_sum_q    <= s1_sum_d;
            s1_exp_q    <= s1_exp_d;
            s2_valid_q  <= s1_valid_q;
            s2_sign_q   <= s1_sign_q;
            s2_zero_q   <= s2_zero_d;
            s2_man_q    <= s2_man_d;
            s2_exp_q    <= s2_exp_d;
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                out_result_q   <= out_result_d;
                out_overflow_q <= out_overflow_d;
                out_inexact_q  <= out_inexact_d;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_result   = out_result_q;
    assign out_overflow = out_overflow_q;
    assign out_inexact  = out_inexact_q;

endmodule
